onchip_mem_burst_adapter: RTL and testbench

- Avalon-MM burst slave front-end that sits directly upstream of the 32-bit, 4096-word single-port on-chip RAM.
- Converts master bursts (read/write, burstcount up to 16) into one-word-per-cycle RAM accesses.
- Generates `waitrequest` and `readdatavalid` toward the master.
- Absorbs the RAM's one-cycle read latency so the master sees a pipelined, in-order read interface.

---
 rtl/onchip_mem_burst_adapter_if.sv | 26 ++
 rtl/onchip_mem_burst_adapter.sv | 129 ++++++++++++
 tb/tb_onchip_mem_burst_adapter.sv | 328 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/onchip_mem_burst_adapter_if.sv
// Avalon-MM burst slave bus seen by the on-chip RAM burst adapter.
interface onchip_mem_burst_adapter_if #(
   parameter int ADDR_W  = 12,
   parameter int DATA_W  = 32,
   parameter int BURST_W = 5
);
   logic [ADDR_W-1:0]   address;
   logic [BURST_W-1:0]  burstcount;
   logic                read;
   logic                write;
   logic [DATA_W-1:0]   writedata;
   logic [DATA_W/8-1:0] byteenable;
   logic                waitrequest;
   logic [DATA_W-1:0]   readdata;
   logic                readdatavalid;

   modport master (
      output address, burstcount, read, write, writedata, byteenable,
      input  waitrequest, readdata, readdatavalid
   );

   modport slave (
      input  address, burstcount, read, write, writedata, byteenable,
      output waitrequest, readdata, readdatavalid
   );
endinterface

// File: rtl/onchip_mem_burst_adapter.sv
// Avalon-MM burst front-end for a single-port on-chip RAM with one-cycle read
// latency. Bursts are unrolled into one RAM access per cycle; read data is
// returned in order through a short valid pipeline.
module onchip_mem_burst_adapter #(
   parameter int ADDR_W  = 12,
   parameter int DATA_W  = 32,
   parameter int BURST_W = 5
) (
   input  logic                clk,
   input  logic                reset_n,
   onchip_mem_burst_adapter_if.slave avs,
   output logic [ADDR_W-1:0]   mem_address,
   output logic [DATA_W/8-1:0] mem_byteenable,
   output logic                mem_chipselect,
   output logic                mem_write,
   output logic [DATA_W-1:0]   mem_writedata,
   output logic                mem_clken,
   input  logic [DATA_W-1:0]   mem_readdata
);
   localparam int BE_W = DATA_W / 8;

   typedef enum logic [1:0] {IDLE, RD_BURST, WR_BURST} state_t;

   state_t              state, state_nxt;
   logic [BURST_W-1:0]  remaining, remaining_nxt;
   logic [ADDR_W-1:0]   next_addr, next_addr_nxt;
   logic                run;
   logic                accept;
   logic                cs_nxt, wr_nxt;
   logic [ADDR_W-1:0]   addr_nxt;
   logic [BE_W-1:0]     be_nxt;
   logic [DATA_W-1:0]   wd_nxt;
   logic                rd_vld_p1;

   // run is low for the first cycle after reset so the bus stays stalled and the RAM clock gated
   assign avs.waitrequest = !run || (state == RD_BURST);
   assign accept          = (avs.read || avs.write) && !avs.waitrequest;
   assign mem_clken       = run;

   // Next-state and next RAM command; writes take priority over reads in IDLE
   always_comb begin
      state_nxt     = state;
      remaining_nxt = remaining;
      next_addr_nxt = next_addr;
      cs_nxt        = 1'b0;
      wr_nxt        = 1'b0;
      addr_nxt      = mem_address;
      be_nxt        = mem_byteenable;
      wd_nxt        = mem_writedata;
      case (state)
         IDLE: begin
            if (accept && (avs.burstcount != '0)) begin
               cs_nxt        = 1'b1;
               addr_nxt      = avs.address;
               next_addr_nxt = avs.address + ADDR_W'(1);
               remaining_nxt = avs.burstcount - BURST_W'(1);
               if (avs.write) begin
                  wr_nxt = 1'b1;
                  be_nxt = avs.byteenable;
                  wd_nxt = avs.writedata;
                  if (avs.burstcount != BURST_W'(1)) state_nxt = WR_BURST;
               end else begin
                  be_nxt = '1;
                  if (avs.burstcount != BURST_W'(1)) state_nxt = RD_BURST;
               end
            end
         end
         RD_BURST: begin
            cs_nxt        = 1'b1;
            addr_nxt      = next_addr;
            be_nxt        = '1;
            next_addr_nxt = next_addr + ADDR_W'(1);
            remaining_nxt = remaining - BURST_W'(1);
            if (remaining == BURST_W'(1)) state_nxt = IDLE;
         end
         WR_BURST: begin
            if (accept && avs.write) begin
               cs_nxt        = 1'b1;
               wr_nxt        = 1'b1;
               addr_nxt      = next_addr;
               be_nxt        = avs.byteenable;
               wd_nxt        = avs.writedata;
               next_addr_nxt = next_addr + ADDR_W'(1);
               remaining_nxt = remaining - BURST_W'(1);
               if (remaining == BURST_W'(1)) state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // FSM state, burst bookkeeping and the post-reset run flag
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state     <= IDLE;
         remaining <= '0;
         next_addr <= '0;
         run       <= 1'b0;
      end else begin
         state     <= state_nxt;
         remaining <= remaining_nxt;
         next_addr <= next_addr_nxt;
         run       <= 1'b1;
      end
   end

   // Registered RAM command (p0) and read-return pipeline (p1 -> bus); reset flushes in-flight reads
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         mem_chipselect    <= 1'b0;
         mem_write         <= 1'b0;
         mem_address       <= '0;
         mem_byteenable    <= '0;
         mem_writedata     <= '0;
         rd_vld_p1         <= 1'b0;
         avs.readdatavalid <= 1'b0;
         avs.readdata      <= '0;
      end else begin
         mem_chipselect    <= cs_nxt;
         mem_write         <= wr_nxt;
         mem_address       <= addr_nxt;
         mem_byteenable    <= be_nxt;
         mem_writedata     <= wd_nxt;
         rd_vld_p1         <= mem_chipselect && !mem_write;
         avs.readdatavalid <= rd_vld_p1;
         if (rd_vld_p1) avs.readdata <= mem_readdata;
      end
   end
endmodule

// File: tb/tb_onchip_mem_burst_adapter.sv
// Randomized bench for onchip_mem_burst_adapter: a transaction-level model
// predicts every RAM access (cycle, address, strobe, lanes, data), every read
// return (cycle, data) and the waitrequest/clken levels, from the commands the
// bench issues.
module tb_onchip_mem_burst_adapter;
   localparam int ADDR_W  = 12;
   localparam int DATA_W  = 32;
   localparam int BURST_W = 5;
   localparam int DEPTH   = 4096;

   typedef struct {
      int          cyc;
      logic [11:0] addr;
      logic        we;
      logic [3:0]  be;
      logic [31:0] data;
   } acc_t;

   typedef struct {
      int          cyc;
      logic [31:0] data;
   } rd_t;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [11:0] mem_address;
   logic [3:0]  mem_byteenable;
   logic        mem_chipselect;
   logic        mem_write;
   logic [31:0] mem_writedata;
   logic        mem_clken;
   logic [31:0] mem_readdata;

   logic [31:0] ram [DEPTH];
   logic [31:0] init_img [DEPTH];
   logic [31:0] shadow [DEPTH];
   logic [31:0] ram_q;
   logic        do_preload = 1'b1;

   int          cyc = 0;
   int          rst_cyc = 0;
   int          wait_until = 0;
   int          wr_left = 0;
   logic [11:0] wr_addr = '0;
   int          n_checks = 0;
   int          n_fail = 0;

   acc_t        acc_q[$];
   acc_t        wp_q[$];
   rd_t         rd_q[$];

   logic [31:0] beat_data [16];
   logic [3:0]  beat_be [16];
   int          beat_idle [16];

   onchip_mem_burst_adapter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST_W(BURST_W)) bus ();

   onchip_mem_burst_adapter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST_W(BURST_W)) dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .avs            (bus),
      .mem_address    (mem_address),
      .mem_byteenable (mem_byteenable),
      .mem_chipselect (mem_chipselect),
      .mem_write      (mem_write),
      .mem_writedata  (mem_writedata),
      .mem_clken      (mem_clken),
      .mem_readdata   (mem_readdata)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Single-port RAM with one-cycle registered read
   always @(posedge clk) begin
      if (do_preload) begin
         for (int i = 0; i < DEPTH; i++) ram[i] <= init_img[i];
      end else if (mem_clken && mem_chipselect) begin
         if (mem_write) begin
            for (int b = 0; b < 4; b++)
               if (mem_byteenable[b]) ram[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
         end else begin
            ram_q <= ram[mem_address];
         end
      end
   end
   assign mem_readdata = ram_q;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd, input logic [3:0] be);
      logic [31:0] r;
      r = old;
      for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
      return r;
   endfunction

   task automatic push_write(input logic [11:0] a, input logic [31:0] d, input logic [3:0] be);
      acc_t e;
      e = '{cyc + 1, a, 1'b1, be, d};
      acc_q.push_back(e);
      wp_q.push_back(e);
   endtask

   // Per-cycle observation at the falling edge: compare, then advance the model
   task automatic observe();
      acc_t a;
      rd_t  r;
      logic exp_wait;
      logic [11:0] ai;
      int n;
      if (cyc == rst_cyc + 1) begin
         check("rst_readdata", 64'(bus.readdata), 64'(0));
         check("rst_mem_address", 64'(mem_address), 64'(0));
         check("rst_mem_be", 64'(mem_byteenable), 64'(0));
         check("rst_mem_write", 64'(mem_write), 64'(0));
         check("rst_mem_wdata", 64'(mem_writedata), 64'(0));
      end
      if (mem_chipselect) begin
         if (acc_q.size() == 0) begin
            check("mem_unexpected_cs", 64'(1), 64'(0));
         end else begin
            a = acc_q.pop_front();
            check("mem_cycle", 64'(cyc), 64'(a.cyc));
            check("mem_address", 64'(mem_address), 64'(a.addr));
            check("mem_write", 64'(mem_write), 64'(a.we));
            check("mem_be", 64'(mem_byteenable), 64'(a.be));
            if (a.we) check("mem_wdata", 64'(mem_writedata), 64'(a.data));
         end
      end else if (acc_q.size() != 0 && acc_q[0].cyc <= cyc) begin
         a = acc_q.pop_front();
         check("mem_missing_cs", 64'(0), 64'(1));
      end
      if (bus.readdatavalid) begin
         if (rd_q.size() == 0) begin
            check("rdv_unexpected", 64'(1), 64'(0));
         end else begin
            r = rd_q.pop_front();
            check("rdv_cycle", 64'(cyc), 64'(r.cyc));
            check("readdata", 64'(bus.readdata), 64'(r.data));
         end
      end else if (rd_q.size() != 0 && rd_q[0].cyc <= cyc) begin
         r = rd_q.pop_front();
         check("rdv_missing", 64'(0), 64'(1));
      end
      exp_wait = (cyc <= wait_until) || (cyc == rst_cyc + 1);
      check("waitrequest", 64'(bus.waitrequest), 64'(exp_wait));
      check("mem_clken", 64'(mem_clken), 64'(cyc > rst_cyc + 1));
      while (wp_q.size() != 0 && wp_q[0].cyc <= cyc) begin
         a = wp_q.pop_front();
         shadow[a.addr] = merge(shadow[a.addr], a.data, a.be);
      end
      if (!reset_n) begin
         rst_cyc = cyc;
         wait_until = 0;
         wr_left = 0;
         acc_q.delete();
         wp_q.delete();
         rd_q.delete();
      end else if (wr_left != 0) begin
         if (bus.write) begin
            push_write(wr_addr, bus.writedata, bus.byteenable);
            wr_addr = wr_addr + 12'd1;
            wr_left--;
         end
      end else if (!exp_wait && (bus.read || bus.write) && bus.burstcount != '0) begin
         n = int'(bus.burstcount);
         if (bus.write) begin
            push_write(bus.address, bus.writedata, bus.byteenable);
            wr_left = n - 1;
            wr_addr = bus.address + 12'd1;
         end else begin
            for (int i = 0; i < n; i++) begin
               ai = bus.address + 12'(i);
               acc_q.push_back('{cyc + 1 + i, ai, 1'b0, 4'hF, 32'h0});
               rd_q.push_back('{cyc + 3 + i, shadow[ai]});
            end
            wait_until = cyc + n - 1;
         end
      end
   endtask

   task automatic step();
      @(negedge clk);
      observe();
      @(posedge clk);
      #1;
   endtask

   task automatic do_cmd(input logic rd, input logic wr, input logic [11:0] a, input int n,
                         input logic [31:0] wd, input logic [3:0] be, output int waits);
      logic got;
      bus.read = rd;
      bus.write = wr;
      bus.address = a;
      bus.burstcount = 5'(n);
      bus.writedata = wd;
      bus.byteenable = be;
      waits = 0;
      got = 1'b0;
      while (!got && waits < 64) begin
         @(negedge clk);
         observe();
         got = !bus.waitrequest;
         @(posedge clk);
         #1;
         if (!got) waits++;
      end
      if (!got) check("accept_timeout", 64'(1), 64'(0));
      bus.read = 1'b0;
      bus.write = 1'b0;
   endtask

   task automatic wr_burst(input logic [11:0] a, input int n, input logic noise);
      int w;
      if (n == 0) begin
         do_cmd(noise, 1'b1, a, 0, beat_data[0], beat_be[0], w);
      end else begin
         for (int i = 0; i < n; i++) begin
            do_cmd(noise & 1'($urandom), 1'b1, a, n, beat_data[i], beat_be[i], w);
            repeat (beat_idle[i]) step();
         end
      end
   endtask

   initial begin
      int w;
      int kind;
      int n;
      logic [11:0] a;
      bus.read = 1'b0;
      bus.write = 1'b0;
      bus.address = '0;
      bus.burstcount = '0;
      bus.writedata = '0;
      bus.byteenable = '0;
      for (int i = 0; i < DEPTH; i++) init_img[i] = $urandom;
      init_img[12'h010] = 32'h12345678;
      init_img[12'h020] = 32'h0;
      init_img[12'h021] = 32'h0;
      init_img[12'h022] = 32'h0;
      for (int i = 0; i < DEPTH; i++) shadow[i] = init_img[i];

      repeat (3) step();
      do_preload = 1'b0;
      reset_n = 1'b1;
      repeat (2) step();

      // single read of a known word
      do_cmd(1'b1, 1'b0, 12'h010, 1, 32'h0, 4'h0, w);
      repeat (5) step();

      // read burst wrapping the top of the address space
      do_cmd(1'b1, 1'b0, 12'hFFE, 4, 32'h0, 4'h0, w);
      repeat (8) step();

      // write burst with partial lanes and an idle between beats 1 and 2, then read back
      beat_data[0] = 32'h11111111; beat_be[0] = 4'hF; beat_idle[0] = 0;
      beat_data[1] = 32'h22222222; beat_be[1] = 4'h3; beat_idle[1] = 1;
      beat_data[2] = 32'h33333333; beat_be[2] = 4'hC; beat_idle[2] = 0;
      wr_burst(12'h020, 3, 1'b0);
      do_cmd(1'b1, 1'b0, 12'h020, 3, 32'h0, 4'h0, w);
      repeat (6) step();

      // zero-length read, then a single read must be accepted at once
      do_cmd(1'b1, 1'b0, 12'h005, 0, 32'h0, 4'h0, w);
      do_cmd(1'b1, 1'b0, 12'h006, 1, 32'h0, 4'h0, w);
      check("bc0_next_accept_waits", 64'(w), 64'(0));
      repeat (5) step();

      // read and write together: the write wins
      do_cmd(1'b1, 1'b1, 12'h030, 1, 32'hA5A5A5A5, 4'hF, w);
      repeat (3) step();
      do_cmd(1'b1, 1'b0, 12'h030, 1, 32'h0, 4'h0, w);
      repeat (5) step();

      // reset pulse during cycle 2 of a 16-beat read
      do_cmd(1'b1, 1'b0, 12'($urandom), 16, 32'h0, 4'h0, w);
      step();
      reset_n = 1'b0;
      step();
      reset_n = 1'b1;
      repeat (20) step();
      do_cmd(1'b1, 1'b0, 12'($urandom), 1, 32'h0, 4'h0, w);
      repeat (5) step();

      // randomized mix of read bursts, write bursts and colliding commands
      for (int t = 0; t < 80; t++) begin
         kind = $urandom_range(0, 9);
         n = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 16);
         a = ($urandom_range(0, 3) == 0) ? 12'(12'hFF0 + 12'($urandom_range(0, 15))) : 12'($urandom);
         if (kind <= 4) begin
            do_cmd(1'b1, 1'b0, a, n, 32'h0, 4'h0, w);
         end else if (kind <= 8) begin
            for (int i = 0; i < 16; i++) begin
               beat_data[i] = $urandom;
               beat_be[i] = 4'($urandom);
               beat_idle[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0;
            end
            wr_burst(a, n, 1'($urandom));
         end else begin
            do_cmd(1'b1, 1'b1, a, 1, $urandom, 4'($urandom), w);
         end
         if ($urandom_range(0, 1) == 0) repeat ($urandom_range(1, 3)) step();
      end

      for (int i = 0; i < 100 && (acc_q.size() != 0 || rd_q.size() != 0); i++) step();
      repeat (4) step();
      check("drain_mem_accesses", 64'(acc_q.size()), 64'(0));
      check("drain_read_returns", 64'(rd_q.size()), 64'(0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
